// File: rtl/histogram_update_ctrl_pkg.sv
// Shared types and constants for the histogram update controller.
package hist_pkg;

  localparam int DEF_DATA_WIDTH = 14;
  localparam int DEF_DATA_DEPTH = 256;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } hist_state_e;

  // Number of bits needed to represent value (clogb2(255) = 8).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    for (r = 0; v > 0; r++) v = v >> 1;
    return r;
  endfunction

endpackage

// File: rtl/histogram_update_ctrl_if.sv
// Pixel stream, accumulator RAM port and readout stream of the histogram
// controller. master = controller side, slave = pixel source / RAM / sink.
interface histogram_update_ctrl_if #(
  parameter int ADDRESS_WIDTH = hist_pkg::clogb2(hist_pkg::DEF_DATA_DEPTH - 1),
  parameter int DATA_WIDTH    = hist_pkg::DEF_DATA_WIDTH
);
  logic [ADDRESS_WIDTH-1:0] pix_data;
  logic                     pix_valid;
  logic                     pix_last;
  logic                     pix_ready;
  logic [ADDRESS_WIDTH-1:0] ram_raddr;
  logic                     ram_rvalid;
  logic                     ram_clear;
  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic                     ram_dvalid;
  logic [ADDRESS_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic                     ram_wvalid;
  logic [ADDRESS_WIDTH-1:0] hist_bin;
  logic [DATA_WIDTH-1:0]    hist_count;
  logic                     hist_valid;
  logic                     hist_last;
  logic                     busy;

  modport master (
    input  pix_data, pix_valid, pix_last, ram_rdata, ram_dvalid,
    output pix_ready, ram_raddr, ram_rvalid, ram_clear, ram_waddr, ram_wdata,
           ram_wvalid, hist_bin, hist_count, hist_valid, hist_last, busy
  );

  modport slave (
    output pix_data, pix_valid, pix_last, ram_rdata, ram_dvalid,
    input  pix_ready, ram_raddr, ram_rvalid, ram_clear, ram_waddr, ram_wdata,
           ram_wvalid, hist_bin, hist_count, hist_valid, hist_last, busy
  );
endinterface

// File: rtl/histogram_update_ctrl_fwd.sv
// hist_fwd_unit: remembers the last RAM write and picks the increment base.
// A same-bin hit one cycle back is read-first stale in the RAM, so the
// previous write data is used instead. Macro HIST_SATURATE_EN selects
// saturating increment; otherwise the counter wraps modulo 2^DATA_WIDTH.
module hist_fwd_unit #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 14
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     wr_valid,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    inc
);
  logic                     wv_q;
  logic [ADDRESS_WIDTH-1:0] wa_q;
  logic [DATA_WIDTH-1:0]    wd_q;
  logic                     hit;
  logic [DATA_WIDTH-1:0]    base;

  assign hit  = wv_q & (wa_q == addr);
  assign base = hit ? wd_q : rd_data;

`ifdef HIST_SATURATE_EN
  assign inc = (&base) ? base : base + DATA_WIDTH'(1);
`else
  assign inc = base + DATA_WIDTH'(1);
`endif

  // Last-write record used for the distance-1 hazard.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wv_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      wv_q <= wr_valid;
      if (wr_valid) begin
        wa_q <= addr;
        wd_q <= inc;
      end
    end
  end
endmodule

// File: rtl/histogram_update_ctrl.sv
// histogram_update_ctrl: pipelined read-modify-write bin increment into a
// 1-cycle-latency clear-on-read RAM, then a full-bin readout per frame.
// Optional macro HIST_SATURATE_EN (in hist_fwd_unit) saturates bin counts.
module histogram_update_ctrl
  import hist_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH
) (
  input  logic                   clk,
  input  logic                   arstn,
  histogram_update_ctrl_if.master bus
);
  localparam int ADDRESS_WIDTH = clogb2(DATA_DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_BIN = ADDRESS_WIDTH'(DATA_DEPTH - 1);

  hist_state_e              state, state_nxt;
  logic                     ready_q;
  logic                     accept;
  logic                     s1_vld;
  logic [ADDRESS_WIDTH-1:0] s1_addr;
  logic                     wvalid;
  logic [DATA_WIDTH-1:0]    inc;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH-1:0] bin_q;
  logic                     rd_q;
  logic                     rvalid;
  logic                     clear;
  logic [ADDRESS_WIDTH-1:0] raddr;

  // ready_q is only ever set while in ACCUM, so it alone qualifies accept.
  assign accept = bus.pix_valid & ready_q;
  assign wvalid = bus.ram_dvalid & s1_vld;

  // Next state and RAM read port mux.
  always_comb begin
    state_nxt = state;
    rvalid    = 1'b0;
    clear     = 1'b0;
    raddr     = '0;
    case (state)
      ACCUM: begin
        rvalid = accept;
        raddr  = accept ? bus.pix_data : '0;
        if (accept && bus.pix_last) state_nxt = DRAIN;
      end
      DRAIN: if (!s1_vld) state_nxt = READ;
      READ: begin
        rvalid = 1'b1;
        clear  = 1'b1;
        raddr  = rd_ptr;
        if (rd_ptr == LAST_BIN) state_nxt = DONE;
      end
      DONE:    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State register; pix_ready is registered so it rises one cycle after reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= ACCUM;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ACCUM);
    end
  end

  // S1: address of the pixel whose read data returns this cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_addr <= bus.pix_data;
    end
  end

  // Readout pointer and the bin tag that travels with the read latency.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rd_ptr <= '0;
      bin_q  <= '0;
      rd_q   <= 1'b0;
    end else begin
      rd_q   <= (state == READ);
      rd_ptr <= (state == READ) ? rd_ptr + ADDRESS_WIDTH'(1) : '0;
      if (state == READ) bin_q <= rd_ptr;
    end
  end

  hist_fwd_unit #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_fwd (
    .clk     (clk),
    .arstn   (arstn),
    .wr_valid(wvalid),
    .addr    (s1_addr),
    .rd_data (bus.ram_rdata),
    .inc     (inc)
  );

  assign bus.pix_ready  = ready_q;
  assign bus.ram_rvalid = rvalid;
  assign bus.ram_clear  = clear;
  assign bus.ram_raddr  = raddr;
  assign bus.ram_wvalid = wvalid;
  assign bus.ram_waddr  = wvalid ? s1_addr : '0;
  assign bus.ram_wdata  = wvalid ? inc : '0;
  // rd_q gating makes the beat drop with reset and hides update-path read data.
  assign bus.hist_valid = rd_q & bus.ram_dvalid;
  assign bus.hist_count = bus.hist_valid ? bus.ram_rdata : '0;
  assign bus.hist_bin   = bin_q;
  assign bus.hist_last  = bus.hist_valid & (bin_q == LAST_BIN);
  assign bus.busy       = (state == DRAIN) || (state == READ);
endmodule

// File: doc/histogram_update_ctrl.md
Name: histogram_update_ctrl

Overview:
- Upstream stage that drives the dual-port histogram accumulator RAM (1-cycle read latency, clear-on-read).
- Accepts a pixel stream and increments the bin for each pixel value using a pipelined read-modify-write.
- Forwarding covers back-to-back same-bin hits.
- On end of frame, drains the pipeline, then streams all bins out while clearing them, ready for the next frame.

Parameters:
- DATA_WIDTH, 14, bin counter width.
- DATA_DEPTH, 256, number of bins; pixel value is used directly as bin address.
- ADDRESS_WIDTH, clogb2(DATA_DEPTH-1), pixel/bin address width (derived localparam).

Ports:
- clk  in  1  single clock
- arstn  in  1  asynchronous active-low reset
- pix_data  in  ADDRESS_WIDTH  pixel value = bin index
- pix_valid  in  1  pixel present
- pix_last  in  1  qualifies last pixel of frame
- pix_ready  out  1  controller accepts pixels (accept = pix_valid & pix_ready)
- ram_raddr  out  ADDRESS_WIDTH  RAM read address
- ram_rvalid  out  1  RAM read strobe
- ram_clear  out  1  clear-on-read request
- ram_rdata  in  DATA_WIDTH  RAM read data
- ram_dvalid  in  1  RAM read data valid (one cycle after ram_rvalid)
- ram_waddr  out  ADDRESS_WIDTH  RAM write address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_wvalid  out  1  RAM write strobe
- hist_bin  out  ADDRESS_WIDTH  readout bin index
- hist_count  out  DATA_WIDTH  readout bin count
- hist_valid  out  1  readout beat valid (no backpressure)
- hist_last  out  1  with final bin (DATA_DEPTH-1)
- busy  out  1  high in DRAIN/READ

Behaviour:
- Reset: all outputs 0 except pix_ready, which is 1 one cycle after reset release. FSM goes to ACCUM; pipeline valids cleared. RAM contents are zeroed by the RAM's own reset.
- FSM states:
  - ACCUM: pix_ready=1. Accepted pixel → ram_rvalid=1, ram_raddr=pix_data, ram_clear=0, in the same cycle (combinational). Stage S1 registers addr/valid. An accepted pix_last → DRAIN.
  - DRAIN: pix_ready=0. Wait until S1 empty (2 cycles after last accept) → READ with rd_ptr=0.
  - READ: ram_rvalid=1, ram_clear=1, ram_raddr=rd_ptr, rd_ptr++ each cycle for DATA_DEPTH cycles.
    - Readout outputs: hist_valid=ram_dvalid, hist_count=ram_rdata, hist_bin=registered rd_ptr. hist_last when hist_bin==DATA_DEPTH-1.
    - After the final read is issued → DONE.
  - DONE: one cycle to let the last beat emerge → ACCUM.
- Update path (S1, cycle after accept):
  - ram_dvalid & S1 valid → ram_wvalid=1, ram_waddr=S1 addr, ram_wdata=base+1 (combinational).
  - The write lands at the end of that cycle.
  - base = wr_data_q (the previous write data, registered) if the previous cycle wrote the same address (fwd hit); otherwise base = ram_rdata.
  - Hazard distance is exactly 1; distance ≥2 reads already see the committed write.
- Arithmetic: increment at DATA_WIDTH bits. Overflow handling is set by the optional feature.
- Simultaneous pix_valid with pix_last in ACCUM: the pixel is counted, then DRAIN.
- pix_valid while pix_ready=0: ignored, not counted.
- Reset mid-READ: readout aborts; hist_valid drops asynchronously; FSM returns to ACCUM.
- Latency: pixel accept → RAM write committed = 2 edges. Frame last accept → first hist_valid = 4 cycles. Readout burst = DATA_DEPTH consecutive beats.

Optional Feature:
- HIST_SATURATE_EN:
  - Defined: a bin at 2^DATA_WIDTH-1 stays at max, and ram_wvalid is still asserted.
  - Undefined: plain modulo wrap to 0.

Decomposition:
- Shared package hist_pkg:
  - FSM state enum (ACCUM, DRAIN, READ, DONE)
  - clogb2 function
  - default DATA_WIDTH/DATA_DEPTH constants
- One natural sub-module: hist_fwd_unit.
  - Registers last write addr/data/valid.
  - Outputs base select and saturating/wrapping +1 result.

Test Plan:
- Pixels 5,9,200 non-consecutive, pix_last on 200 → readout: bins 5,9,200 = 1, all other 253 bins = 0. hist_last on bin 255. 256 consecutive beats.
- Back-to-back pixel 7 ×10 cycles with pix_last on the 10th → bin 7 = 10 (forwarding check). Same test with pixel 7,8,7,8 alternating → bins 7 = 2, 8 = 2.
- Two frames back-to-back → second readout reflects only the second frame (clear-on-read verified). pix_ready is 0 from the cycle after pix_last through DONE.
- DATA_WIDTH=4, 20 hits on bin 3 → bin 3 = 15 with HIST_SATURATE_EN, bin 3 = 4 without.
- pix_valid held high during DRAIN/READ with value 1 → bin 1 unchanged in the next frame's readout.
- arstn pulsed at readout beat 100 → hist_valid=0 immediately. FSM resumes in ACCUM. Next frame of pixel 0 ×3 → bin 0 = 3.
